// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   state_e       : frame sequencing states of the scheduler FSM
//   BLANK_PTS/LES : driver masks that leave every digit and point dark
//   onehot_to_idx : encodes a one-hot grant (up to 8 sources) to an index
package seg_disp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_RISE = 3'd4,
    WAIT_FALL = 3'd5
  } state_e;

  localparam logic [7:0] BLANK_PTS = 8'hFF;
  localparam logic [7:0] BLANK_LES = 8'hFF;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_disp_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector, bit 0 = lowest index
//   last  : index of the previous winner; the search starts just after it
//   next  : one-hot winner (all-zero when no request)
//   valid : at least one request is high
module rr_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [NUM_SRC-1:0] next,
  output logic               valid
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    next  = '0;
    valid = 1'b0;
    idx   = '0;
    // Offsets 1..NUM_SRC so that 'last' itself is considered only after
    // every other source has been passed over.
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = SEL_W'((32'(last) + off) % NUM_SRC);
      if (!valid && req[idx]) begin
        next[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Shares one serial 8-digit seven-segment driver among NUM_SRC requesters.
//   clk, rst        : clock, asynchronous active-high reset
//   src_req         : level request per source
//   src_hex/src_pts : packed per-source digits (32b) and point masks (8b)
//   drv_busy        : driver is shifting a frame
//   disp_hexs/points/les : frame data held stable from LOAD to next LOAD
//   disp_start      : one-cycle frame start pulse
//   src_grant/cur_src : one-hot owner and its index
module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned REFRESH_CYCLES = 1048576,
  parameter int unsigned DWELL_FRAMES   = 64,
  parameter int unsigned BUSY_TIMEOUT   = 16,
  localparam int unsigned SEL_W         = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [32*NUM_SRC-1:0] src_hex,
  input  logic [8*NUM_SRC-1:0]  src_pts,
  input  logic                  drv_busy,
  output logic [31:0]           disp_hexs,
  output logic [7:0]            disp_points,
  output logic [7:0]            disp_les,
  output logic                  disp_start,
  output logic [NUM_SRC-1:0]    src_grant,
  output logic [SEL_W-1:0]      cur_src
);

  localparam int unsigned TMR_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned DW_W  = $clog2(DWELL_FRAMES + 1);
  localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [DW_W-1:0]  DW_MAX   = DW_W'(DWELL_FRAMES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_TOP  = SEL_W'(NUM_SRC - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               pend_q, pend_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [31:0]        hexs_q, hexs_d;
  logic [7:0]         pts_q, pts_d;
  logic [7:0]         les_q, les_d;
  logic               start_q, start_d;

  logic               due, have_owner, others, keep;
  logic [SEL_W-1:0]   arb_last;
  logic [NUM_SRC-1:0] arb_next;
  logic               arb_valid;

  assign due        = (tmr_q == TMR_LAST);
  assign have_owner = |grant_q;
  assign others     = |(src_req & ~grant_q);
  assign keep       = have_owner && src_req[cur_q] && ((dwell_q < DW_MAX) || !others);

  // With no owner the rr pointer itself is the first candidate, so the
  // search is started from the index just before it.
  always_comb begin
    arb_last = cur_q;
    if (!have_owner) arb_last = (cur_q == '0) ? SEL_TOP : cur_q - 1'b1;
  end

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req   (src_req),
    .last  (arb_last),
    .next  (arb_next),
    .valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = due ? '0 : tmr_q + 1'b1;
    pend_d  = pend_q | due;
    dwell_d = dwell_q;
    to_d    = to_q;
    grant_d = grant_q;
    cur_d   = cur_q;
    hexs_d  = hexs_q;
    pts_d   = pts_q;
    les_d   = les_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (pend_q) begin
        pend_d  = due;
        state_d = ARB;
      end
      ARB: begin
        state_d = LOAD;
        if (!keep) begin
          dwell_d = '0;
          grant_d = arb_next;
          if (arb_valid) cur_d = SEL_W'(onehot_to_idx(8'(arb_next)));
        end
      end
      LOAD: begin
        state_d = START;
        if (have_owner) begin
          hexs_d = src_hex[32*cur_q +: 32];
          pts_d  = src_pts[8*cur_q +: 8];
          les_d  = '0;
        end else begin
          hexs_d = '0;
          pts_d  = BLANK_PTS;
          les_d  = BLANK_LES;
        end
      end
      START: if (!drv_busy) begin
        start_d = 1'b1;
        to_d    = '0;
        state_d = WAIT_RISE;
        if (have_owner && dwell_q != DW_MAX) dwell_d = dwell_q + 1'b1;
      end
      WAIT_RISE: begin
        if (drv_busy)            state_d = WAIT_FALL;
        else if (to_q == TO_LAST) state_d = IDLE;
        else                     to_d = to_q + 1'b1;
      end
      WAIT_FALL: if (!drv_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      dwell_q <= '0;
      to_q    <= '0;
      grant_q <= '0;
      cur_q   <= '0;
      hexs_q  <= '0;
      pts_q   <= BLANK_PTS;
      les_q   <= BLANK_LES;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      dwell_q <= dwell_d;
      to_q    <= to_d;
      grant_q <= grant_d;
      cur_q   <= cur_d;
      hexs_q  <= hexs_d;
      pts_q   <= pts_d;
      les_q   <= les_d;
      start_q <= start_d;
    end
  end

  assign disp_hexs   = hexs_q;
  assign disp_points = pts_q;
  assign disp_les    = les_q;
  assign disp_start  = start_q;
  assign src_grant   = grant_q;
  assign cur_src     = cur_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with short refresh period and dwell.
module tb_seg_disp_sched;

  localparam int unsigned NS  = 4;
  localparam int unsigned REF = 100;

  logic          clk, rst, drv_busy;
  logic [NS-1:0] src_req;
  logic [127:0]  src_hex;
  logic [31:0]   src_pts;
  logic [31:0]   disp_hexs;
  logic [7:0]    disp_points, disp_les;
  logic          disp_start;
  logic [NS-1:0] src_grant;
  logic [1:0]    cur_src;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bcnt = 0;
  bit busy_auto = 1'b1;
  bit busy_force = 1'b0;

  seg_disp_sched #(
    .NUM_SRC(NS), .REFRESH_CYCLES(REF), .DWELL_FRAMES(4), .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_hex(src_hex), .src_pts(src_pts),
    .drv_busy(drv_busy), .disp_hexs(disp_hexs), .disp_points(disp_points),
    .disp_les(disp_les), .disp_start(disp_start), .src_grant(src_grant), .cur_src(cur_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: busy for 40 cycles after each start when enabled.
  always @(negedge clk) begin
    if (disp_start && busy_auto) bcnt <= 40;
    else if (bcnt > 0)           bcnt <= bcnt - 1;
  end
  assign drv_busy = busy_force | (bcnt > 0);

  task automatic wait_start(input int limit, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (disp_start === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    int t0, t1, t2;
    src_req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (disp_hexs !== 32'h0 || disp_points !== 8'hFF || disp_les !== 8'hFF ||
        disp_start !== 1'b0 || src_grant !== 4'b0 || cur_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_vals: hexs=%h pts=%h les=%h start=%b grant=%b cur=%0d want 0/ff/ff/0/0/0",
               disp_hexs, disp_points, disp_les, disp_start, src_grant, cur_src);
    end
    rst = 1'b0;
    t0 = cyc;
    wait_start(300, ok, t1);
    checks++;
    if (!ok || (t1 - t0) < REF || (t1 - t0) > REF + 8) begin
      failures++;
      $display("FAIL first_start_delay: got ok=%0d delay=%0d want %0d..%0d", ok, t1 - t0, REF, REF + 8);
    end
    checks++;
    if (disp_les !== 8'hFF || disp_hexs !== 32'h0 || src_grant !== 4'b0) begin
      failures++;
      $display("FAIL idle_frame: les=%h hexs=%h grant=%b want ff/0/0", disp_les, disp_hexs, src_grant);
    end
    for (int k = 0; k < 2; k++) begin
      wait_start(300, ok, t2);
      checks++;
      if (!ok || (t2 - t1) != REF) begin
        failures++;
        $display("FAIL start_spacing: got ok=%0d spacing=%0d want %0d", ok, t2 - t1, REF);
      end
      t1 = t2;
    end
  endtask

  task automatic test_single_owner;
    bit ok;
    int t;
    src_hex[63:32] = 32'h0000_1234;
    src_pts[15:8]  = 8'hF0;
    src_req = 4'b0010;
    wait_start(300, ok, t);
    checks++;
    if (!ok || src_grant !== 4'b0010 || cur_src !== 2'd1 || disp_hexs !== 32'h0000_1234 ||
        disp_les !== 8'h00 || disp_points !== 8'hF0) begin
      failures++;
      $display("FAIL single_owner: ok=%0d grant=%b cur=%0d hexs=%h les=%h pts=%h want 0010/1/00001234/00/f0",
               ok, src_grant, cur_src, disp_hexs, disp_les, disp_points);
    end
    repeat (5) @(negedge clk);
    src_hex[63:32] = 32'h0000_5678;
    repeat (10) @(negedge clk);
    checks++;
    if (disp_hexs !== 32'h0000_1234) begin
      failures++;
      $display("FAIL hex_hold: got %h want 00001234", disp_hexs);
    end
    wait_start(300, ok, t);
    checks++;
    if (!ok || disp_hexs !== 32'h0000_5678) begin
      failures++;
      $display("FAIL hex_reload: ok=%0d got %h want 00005678", ok, disp_hexs);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int t;
    int exp_idx;
    logic [3:0] exp_g;
    src_req = 4'b0101;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 12; f++) begin
      exp_idx = ((f / 4) % 2 == 1) ? 2 : 0;
      exp_g = 4'b0001 << exp_idx;
      wait_start(300, ok, t);
      checks++;
      if (!ok || cur_src !== 2'(exp_idx) || src_grant !== exp_g) begin
        failures++;
        $display("FAIL rr_frame%0d: ok=%0d cur=%0d grant=%b want cur=%0d grant=%b",
                 f, ok, cur_src, src_grant, exp_idx, exp_g);
      end
    end
  endtask

  task automatic test_busy_stall;
    bit ok;
    int t, r, n, first;
    wait_start(300, ok, t);
    busy_force = 1'b1;
    n = 0;
    for (int i = 0; i < 230; i++) begin
      @(negedge clk);
      if (disp_start === 1'b1) n++;
    end
    checks++;
    if (!ok || n != 0) begin
      failures++;
      $display("FAIL stall_no_start: ok=%0d starts=%0d want 0", ok, n);
    end
    busy_force = 1'b0;
    r = cyc;
    n = 0;
    first = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (disp_start === 1'b1) begin
        n++;
        if (first < 0) first = cyc - r;
      end
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL stall_one_start: got %0d starts want 1", n);
    end
    checks++;
    if (first < 0 || first > 8) begin
      failures++;
      $display("FAIL stall_latency: got %0d cycles want 0..8", first);
    end
  endtask

  task automatic test_busy_timeout;
    bit ok1, ok2;
    int t1, t2;
    busy_auto = 1'b0;
    wait_start(300, ok1, t1);
    wait_start(300, ok2, t2);
    checks++;
    if (!ok1 || !ok2 || (t2 - t1) != REF) begin
      failures++;
      $display("FAIL timeout_recover: ok=%0d/%0d spacing=%0d want %0d", ok1, ok2, t2 - t1, REF);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int t, t0;
    busy_auto = 1'b1;
    src_req = 4'b0001;
    src_pts[7:0] = 8'h0F;
    src_hex[31:0] = 32'hCAFE_0001;
    wait_start(300, ok, t);
    wait_start(300, ok, t);
    checks++;
    if (!ok || src_grant !== 4'b0001 || disp_points !== 8'h0F || disp_hexs !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL pre_reset_owner: ok=%0d grant=%b pts=%h hexs=%h want 0001/0f/cafe0001",
               ok, src_grant, disp_points, disp_hexs);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (disp_start !== 1'b0 || src_grant !== 4'b0 || disp_points !== 8'hFF ||
        disp_les !== 8'hFF || disp_hexs !== 32'h0 || cur_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_frame: start=%b grant=%b pts=%h les=%h hexs=%h cur=%0d want 0/0/ff/ff/0/0",
               disp_start, src_grant, disp_points, disp_les, disp_hexs, cur_src);
    end
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    wait_start(300, ok, t);
    checks++;
    if (!ok || (t - t0) < REF || (t - t0) > REF + 8) begin
      failures++;
      $display("FAIL post_reset_delay: ok=%0d delay=%0d want %0d..%0d", ok, t - t0, REF, REF + 8);
    end
  endtask

  initial begin
    rst = 1'b1;
    src_req = '0;
    src_hex = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    src_pts = 32'h33_22_11_00;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_busy_stall();
    test_busy_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
